// File: rtl/arb_mux_pkg.sv
// Shared constants for the arb_mux_nto1 N-to-1 arbitrated selector.
//   MODE_FIXED : lowest eligible channel index wins every time
//   MODE_RR    : round-robin, scanning upward from the channel after the
//                last one granted
package arb_mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

endpackage

// File: rtl/arb_mux_nto1_prio_pick.sv
// prio_pick: combinational rotating priority picker.
//   req     in   N      request vector
//   start   in   SEL_W  index scanned first; the scan wraps from N-1 to 0
//   gnt_idx out  SEL_W  first requesting index found (0 when none)
//   gnt_any out  1      at least one request is set
module prio_pick #(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    always_comb begin
        int unsigned v_idx;
        gnt_idx = '0;
        gnt_any = 1'b0;
        v_idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            // start is always below N, so one subtraction performs the wrap
            v_idx = 32'(start) + k;
            if (v_idx >= N) v_idx = v_idx - N;
            if (!gnt_any && req[v_idx[SEL_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = v_idx[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/arb_mux_nto1.sv
// arb_mux_nto1: N-to-1 data selector with per-channel valid/ready,
// internal arbitration (fixed priority or round-robin) and one registered
// output stage. force_en/force_sel limit eligibility to a single channel.
//   clk, rst_n          clock; synchronous active-low reset
//   din / din_valid     N channels, channel i at din[i*WIDTH +: WIDTH]
//   din_ready           one-hot (or zero) accept back to the channels
//   force_en/force_sel  only channel force_sel is eligible when force_en=1
//   dout/dout_valid     registered output word and its valid flag
//   dout_ready          consumer accepts dout this cycle
//   dout_src            channel index that produced dout
module arb_mux_nto1
    import arb_mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int MODE  = MODE_RR,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   din,
    input  logic [N-1:0]         din_valid,
    output logic [N-1:0]         din_ready,
    input  logic                 force_en,
    input  logic [SEL_W-1:0]     force_sel,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [SEL_W-1:0]     dout_src
);

    logic [N-1:0]     w_elig;
    logic [SEL_W-1:0] w_start;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_gnt_any;
    logic             w_load;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic [SEL_W-1:0] r_dout_src;
    logic [SEL_W-1:0] r_rr_ptr;

    // A force_sel at or above N matches no channel, so nothing is eligible
    always_comb begin
        w_elig = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_elig[i] = din_valid[i] && (!force_en || (32'(force_sel) == i));
        end
    end

    assign w_start = (MODE == MODE_RR) ? r_rr_ptr : '0;

    prio_pick #(.N(N)) u_pick (
        .req     (w_elig),
        .start   (w_start),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    // Output register can take a new word when empty or being drained
    assign w_load = !r_dout_valid || dout_ready;
    // Gated by rst_n so no handshake completes on a reset cycle
    assign w_xfer = rst_n && w_load && w_gnt_any;

    always_comb begin
        din_ready = '0;
        if (w_xfer) din_ready[w_gnt_idx] = 1'b1;
    end

    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(w_gnt_idx) == i) w_sel_data = din[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_src   <= '0;
            r_rr_ptr     <= '0;
        end else if (w_load) begin
            if (w_xfer) begin
                r_dout       <= w_sel_data;
                r_dout_src   <= w_gnt_idx;
                r_dout_valid <= 1'b1;
                if (MODE == MODE_RR) begin
                    r_rr_ptr <= (w_gnt_idx == SEL_W'(N-1)) ? '0 : w_gnt_idx + 1'b1;
                end
            end else begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_src   = r_dout_src;

endmodule

// File: tb/tb_arb_mux_nto1.sv
module tb_arb_mux_nto1;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [5*W-1:0] din;
    logic [4:0]     din_valid;
    logic           force_en;
    logic [2:0]     force_sel;
    logic           dout_ready;

    logic [3:0]   rdy_a, rdy_b;
    logic [4:0]   rdy_c;
    logic [W-1:0] dout_a, dout_b, dout_c;
    logic         val_a, val_b, val_c;
    logic [1:0]   src_a, src_b;
    logic [2:0]   src_c;

    always #5 clk = ~clk;

    arb_mux_nto1 #(.WIDTH(W), .N(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .din(din[4*W-1:0]), .din_valid(din_valid[3:0]),
        .din_ready(rdy_a), .force_en(force_en), .force_sel(force_sel[1:0]),
        .dout(dout_a), .dout_valid(val_a), .dout_ready(dout_ready), .dout_src(src_a));

    arb_mux_nto1 #(.WIDTH(W), .N(4), .MODE(0)) u_fix4 (
        .clk(clk), .rst_n(rst_n), .din(din[4*W-1:0]), .din_valid(din_valid[3:0]),
        .din_ready(rdy_b), .force_en(force_en), .force_sel(force_sel[1:0]),
        .dout(dout_b), .dout_valid(val_b), .dout_ready(dout_ready), .dout_src(src_b));

    arb_mux_nto1 #(.WIDTH(W), .N(5), .MODE(1)) u_rr5 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(rdy_c), .force_en(force_en), .force_sel(force_sel),
        .dout(dout_c), .dout_valid(val_c), .dout_ready(dout_ready), .dout_src(src_c));

    // Outputs of the instance currently under check
    int unsigned  sel;
    logic [4:0]   s_rdy;
    logic [W-1:0] s_dout;
    logic         s_valid;
    logic [2:0]   s_src;

    always_comb begin
        case (sel)
            0:       begin s_rdy = {1'b0, rdy_a}; s_dout = dout_a; s_valid = val_a; s_src = {1'b0, src_a}; end
            1:       begin s_rdy = {1'b0, rdy_b}; s_dout = dout_b; s_valid = val_b; s_src = {1'b0, src_b}; end
            default: begin s_rdy = rdy_c;         s_dout = dout_c; s_valid = val_c; s_src = src_c;         end
        endcase
    end

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    typedef struct packed {
        logic [W-1:0] data;
        logic [2:0]   src;
    } word_t;

    word_t        sbq[$];
    int unsigned  cur_n, cur_mode, m_rr;
    logic         m_valid;
    logic [W-1:0] m_dout;
    logic [2:0]   m_src;

    // One clock: predict grant/ready from the model, push the expected word,
    // then pop it after the edge and compare the registered outputs.
    task automatic step();
        logic [4:0]  elig;
        logic [4:0]  exp_rdy;
        logic        load, any, xfer;
        int unsigned g, c;
        word_t       w;
        #1;
        elig = '0;
        for (int unsigned i = 0; i < cur_n; i++)
            elig[i] = din_valid[i] && (!force_en || force_sel == 3'(i));
        load = !m_valid || dout_ready;
        any  = 1'b0;
        g    = 0;
        for (int unsigned k = 0; k < cur_n; k++) begin
            c = (cur_mode == 1) ? (m_rr + k) % cur_n : k;
            if (!any && elig[c]) begin any = 1'b1; g = c; end
        end
        xfer    = rst_n && load && any;
        exp_rdy = xfer ? (5'd1 << g) : 5'd0;
        chk("din_ready", 32'(s_rdy), 32'(exp_rdy));
        if (xfer) begin
            w.data = din[g*W +: W];
            w.src  = 3'(g);
            sbq.push_back(w);
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            sbq.delete();
            m_valid = 1'b0; m_dout = '0; m_src = '0; m_rr = 0;
        end else if (load) begin
            if (xfer) begin
                if (sbq.size() > 0) begin
                    w = sbq.pop_front();
                    m_dout = w.data; m_src = w.src;
                end
                m_valid = 1'b1;
                if (cur_mode == 1) m_rr = (g == cur_n - 1) ? 0 : g + 1;
            end else begin
                m_valid = 1'b0;
            end
        end
        chk("dout_valid", 32'(s_valid), 32'(m_valid));
        chk("dout", s_dout, m_dout);
        chk("dout_src", 32'(s_src), 32'(m_src));
        @(negedge clk);
    endtask

    task automatic load_default_data();
        for (int unsigned i = 0; i < 5; i++) din[i*W +: W] = 32'hA5A5_0000 + i;
    endtask

    task automatic start_phase(input int unsigned s, input int unsigned n, input int unsigned mode);
        sel = s; cur_n = n; cur_mode = mode;
        load_default_data();
        rst_n = 1'b0; din_valid = '1; force_en = 1'b0; force_sel = '0; dout_ready = 1'b1;
        step();
        chk("rst_dout", s_dout, 32'h0);
        chk("rst_valid", 32'(s_valid), 32'h0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic random_phase(input int unsigned cycles, input int unsigned fs_max);
        for (int unsigned t = 0; t < cycles; t++) begin
            for (int unsigned i = 0; i < 5; i++) din[i*W +: W] = $urandom;
            din_valid  = 5'($urandom);
            dout_ready = ($urandom_range(0, 3) != 0);
            force_en   = ($urandom_range(0, 3) == 0);
            force_sel  = 3'($urandom_range(0, fs_max));
            step();
        end
        force_en = 1'b0;
        load_default_data();
    endtask

    logic [1:0] rr_seq [6];

    initial begin
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        m_valid = 1'b0; m_dout = '0; m_src = '0; m_rr = 0;

        // Round-robin, N=4
        start_phase(0, 4, 1);
        din_valid = 5'b01111;
        for (int unsigned k = 0; k < 6; k++) begin
            step();
            chk("rr_seq", 32'(s_src), 32'(rr_seq[k]));
        end
        // Stall holding channel 2's word, then channel 3 is next
        din_valid = 5'b00100;
        step();
        din_valid = 5'b01111; dout_ready = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            step();
            chk("stall_dout", s_dout, 32'hA5A5_0002);
            chk("stall_rdy", 32'(s_rdy), 32'h0);
        end
        dout_ready = 1'b1;
        step();
        chk("post_stall_src", 32'(s_src), 32'h3);
        // Forced channel 2 not requesting: nothing moves
        force_en = 1'b1; force_sel = 3'd2; din_valid = 5'b00011;
        step(); step();
        chk("force_idle", 32'(s_valid), 32'h0);
        din_valid = 5'b00111;
        step();
        chk("force_src", 32'(s_src), 32'h2);
        force_en = 1'b0;
        // Reset during a stall clears the held word and the pointer
        din_valid = 5'b01111;
        step(); step();
        dout_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_valid", 32'(s_valid), 32'h0);
        rst_n = 1'b1; dout_ready = 1'b1;
        step();
        chk("midrst_rr0", 32'(s_src), 32'h0);
        din_valid = 5'b01000;
        step();
        chk("midrst_src3", 32'(s_src), 32'h3);
        random_phase(60, 3);

        // Fixed priority, N=4: channel 3 starves behind channel 1
        start_phase(1, 4, 0);
        din_valid = 5'b01010;
        for (int unsigned k = 0; k < 5; k++) begin
            step();
            chk("fixed_src", 32'(s_src), 32'h1);
        end
        random_phase(60, 3);

        // Round-robin, N=5 (3-bit select): out-of-range force_sel
        start_phase(2, 5, 1);
        force_en = 1'b1; force_sel = 3'd5; din_valid = 5'b11111;
        step();
        chk("fsel5_rdy", 32'(s_rdy), 32'h0);
        step();
        chk("fsel5_valid", 32'(s_valid), 32'h0);
        force_sel = 3'd7;
        step();
        force_sel = 3'd4;
        step();
        chk("fsel4_src", 32'(s_src), 32'h4);
        force_en = 1'b0;
        random_phase(60, 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
